// File: rtl/burst_tx_sequencer_if.sv
// Byte transmit handshake between the burst sequencer and a downstream transmitter.
interface burst_tx_sequencer_if;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] tx_data;

    modport master (
        output tx_valid,
        output tx_data,
        input  tx_ready
    );

    modport slave (
        input  tx_valid,
        input  tx_data,
        output tx_ready
    );
endinterface

// File: rtl/burst_tx_sequencer.sv
// Burst transmit sequencer: sends cfg_bytes counting-up bytes over a valid/ready
// handshake with a programmable inter-byte gap, and drives 7-seg display fields.
module burst_tx_sequencer #(
    parameter int unsigned TICK_DIV = 100000
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        start,
    input  logic                        abort,
    input  logic [7:0]                  cfg_bytes,
    input  logic [7:0]                  cfg_speed,
    input  logic [7:0]                  cfg_first,
    burst_tx_sequencer_if.master        tx,
    output logic                        busy,
    output logic                        done,
    output logic [7:0]                  disp_num,
    output logic [7:0]                  disp_speed,
    output logic [7:0]                  disp_bytes,
    output logic [7:0]                  disp_count
);

    // Keep the prescaler at least one bit wide so TICK_DIV = 1 still elaborates.
    localparam int unsigned PscW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PscW-1:0] PscMax = PscW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        StIdle,
        StSend,
        StGap,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [7:0]      bytes_q, bytes_d;
    logic [7:0]      speed_q, speed_d;
    logic [7:0]      data_q, data_d;
    logic            tx_valid_q, tx_valid_d;
    logic            busy_q, busy_d;
    logic            done_q, done_d;
    logic [7:0]      disp_num_q, disp_num_d;
    logic [7:0]      disp_speed_q, disp_speed_d;
    logic [7:0]      disp_bytes_q, disp_bytes_d;
    logic [7:0]      disp_count_q, disp_count_d;
    logic [PscW-1:0] psc_q, psc_d;
    logic [7:0]      gap_q, gap_d;

    logic            xfer;
    logic [7:0]      count_inc;

    assign xfer      = tx_valid_q & tx.tx_ready;
    assign count_inc = disp_count_q + 8'd1;

    // State register and all registered outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= StIdle;
            bytes_q      <= '0;
            speed_q      <= '0;
            data_q       <= '0;
            tx_valid_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            disp_num_q   <= '0;
            disp_speed_q <= '0;
            disp_bytes_q <= '0;
            disp_count_q <= '0;
            psc_q        <= '0;
            gap_q        <= '0;
        end else begin
            state_q      <= state_d;
            bytes_q      <= bytes_d;
            speed_q      <= speed_d;
            data_q       <= data_d;
            tx_valid_q   <= tx_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            disp_num_q   <= disp_num_d;
            disp_speed_q <= disp_speed_d;
            disp_bytes_q <= disp_bytes_d;
            disp_count_q <= disp_count_d;
            psc_q        <= psc_d;
            gap_q        <= gap_d;
        end
    end

    // Next-state logic; outputs are derived from the next state so they stay registered.
    always_comb begin
        state_d      = state_q;
        bytes_d      = bytes_q;
        speed_d      = speed_q;
        data_d       = data_q;
        disp_num_d   = disp_num_q;
        disp_speed_d = disp_speed_q;
        disp_bytes_d = disp_bytes_q;
        disp_count_d = disp_count_q;
        psc_d        = psc_q;
        gap_d        = gap_q;

        unique case (state_q)
            StIdle: begin
                disp_speed_d = cfg_speed;
                disp_bytes_d = cfg_bytes;
                if (start && !abort) begin
                    bytes_d      = cfg_bytes;
                    speed_d      = cfg_speed;
                    data_d       = cfg_first;
                    disp_count_d = 8'd0;
                    state_d      = (cfg_bytes == 8'd0) ? StDone : StSend;
                end
            end

            StSend: begin
                if (xfer) begin
                    // A transfer on the abort edge still counts.
                    disp_num_d   = data_q;
                    disp_count_d = count_inc;
                    data_d       = data_q + 8'd1;
                    if (abort) begin
                        state_d = StIdle;
                    end else if (count_inc == bytes_q) begin
                        state_d = StDone;
                    end else if (speed_q != 8'd0) begin
                        state_d = StGap;
                        psc_d   = '0;
                        gap_d   = 8'd0;
                    end
                end else if (abort) begin
                    state_d = StIdle;
                end
            end

            StGap: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (gap_q == speed_q) begin
                    state_d = StSend;
                end else if (psc_q == PscMax) begin
                    psc_d = '0;
                    gap_d = gap_q + 8'd1;
                end else begin
                    psc_d = psc_q + 1'b1;
                end
            end

            StDone: begin
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase

        tx_valid_d = (state_d == StSend);
        busy_d     = (state_d != StIdle);
        done_d     = (state_d == StDone);
    end

    assign tx.tx_valid = tx_valid_q;
    assign tx.tx_data  = data_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign disp_num    = disp_num_q;
    assign disp_speed  = disp_speed_q;
    assign disp_bytes  = disp_bytes_q;
    assign disp_count  = disp_count_q;

endmodule

// File: tb/tb_burst_tx_sequencer.sv
// Scoreboard bench for burst_tx_sequencer: expected bytes and done snapshots are queued
// by the stimulus; a negedge monitor pops and compares on each transfer and done pulse.
module tb_burst_tx_sequencer;

    logic       clk;
    logic       reset;
    logic       start;
    logic       abort;
    logic [7:0] cfg_bytes;
    logic [7:0] cfg_speed;
    logic [7:0] cfg_first;
    logic       busy;
    logic       done;
    logic [7:0] disp_num;
    logic [7:0] disp_speed;
    logic [7:0] disp_bytes;
    logic [7:0] disp_count;

    burst_tx_sequencer_if bus ();

    burst_tx_sequencer #(
        .TICK_DIV (4)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .cfg_bytes  (cfg_bytes),
        .cfg_speed  (cfg_speed),
        .cfg_first  (cfg_first),
        .tx         (bus.master),
        .busy       (busy),
        .done       (done),
        .disp_num   (disp_num),
        .disp_speed (disp_speed),
        .disp_bytes (disp_bytes),
        .disp_count (disp_count)
    );

    int checks = 0;
    int errors = 0;

    logic [7:0]  exp_bytes[$];
    logic [15:0] exp_done[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int n = 0;
        while (busy && n < limit) begin
            tick(1);
            n++;
        end
        check("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_valid"}, {31'd0, bus.tx_valid}, 32'd0);
        check({tag, "_data"}, {24'd0, bus.tx_data}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
        check({tag, "_done"}, {31'd0, done}, 32'd0);
        check({tag, "_num"}, {24'd0, disp_num}, 32'd0);
        check({tag, "_speed"}, {24'd0, disp_speed}, 32'd0);
        check({tag, "_bytes"}, {24'd0, disp_bytes}, 32'd0);
        check({tag, "_count"}, {24'd0, disp_count}, 32'd0);
    endtask

    // Monitor: compare every handshake and every done pulse against the scoreboard.
    always @(negedge clk) begin
        if (reset) begin
            if (bus.tx_valid && bus.tx_ready) begin
                if (exp_bytes.size() == 0) begin
                    check("unexpected_tx", {24'd0, bus.tx_data}, 32'hFFFF_FFFF);
                end else begin
                    check("tx_data", {24'd0, bus.tx_data}, {24'd0, exp_bytes.pop_front()});
                end
            end
            if (done) begin
                if (exp_done.size() == 0) begin
                    check("unexpected_done", {16'd0, disp_count, disp_num}, 32'hFFFF_FFFF);
                end else begin
                    check("done_count_num", {16'd0, disp_count, disp_num},
                          {16'd0, exp_done.pop_front()});
                end
            end
        end
    end

    initial begin
        int n;
        reset        = 1'b0;
        start        = 1'b0;
        abort        = 1'b0;
        cfg_bytes    = 8'h34;
        cfg_speed    = 8'h12;
        cfg_first    = 8'h00;
        bus.tx_ready = 1'b0;

        // 1. Reset state and display tracking in IDLE.
        tick(3);
        check_all_zero("reset");
        reset = 1'b1;
        tick(1);
        check("idle_busy", {31'd0, busy}, 32'd0);
        check("idle_disp_speed", {24'd0, disp_speed}, 32'h12);
        check("idle_disp_bytes", {24'd0, disp_bytes}, 32'h34);
        cfg_speed = 8'h56;
        cfg_bytes = 8'h78;
        tick(1);
        check("track_disp_speed", {24'd0, disp_speed}, 32'h56);
        check("track_disp_bytes", {24'd0, disp_bytes}, 32'h78);

        // 2. Back-to-back burst with data wrap FE, FF, 00.
        cfg_bytes    = 8'd3;
        cfg_speed    = 8'd0;
        cfg_first    = 8'hFE;
        bus.tx_ready = 1'b1;
        exp_bytes.push_back(8'hFE);
        exp_bytes.push_back(8'hFF);
        exp_bytes.push_back(8'h00);
        exp_done.push_back({8'd3, 8'h00});
        pulse_start();
        for (int i = 0; i < 3; i++) begin
            check("b2b_valid", {31'd0, bus.tx_valid}, 32'd1);
            tick(1);
        end
        check("b2b_done", {31'd0, done}, 32'd1);
        check("b2b_valid_low", {31'd0, bus.tx_valid}, 32'd0);
        tick(1);
        check("b2b_done_end", {31'd0, done}, 32'd0);
        check("b2b_busy_end", {31'd0, busy}, 32'd0);
        check("b2b_count", {24'd0, disp_count}, 32'd3);
        check("b2b_num", {24'd0, disp_num}, 32'h00);

        // 3. Gap timing: TICK_DIV=4, speed=2 -> tx_valid re-rises 9 cycles after handshake.
        cfg_bytes = 8'd2;
        cfg_speed = 8'd2;
        cfg_first = 8'h10;
        exp_bytes.push_back(8'h10);
        exp_bytes.push_back(8'h11);
        exp_done.push_back({8'd2, 8'h11});
        pulse_start();
        check("gap_first_valid", {31'd0, bus.tx_valid}, 32'd1);
        tick(1);
        cfg_speed = 8'd7;
        cfg_bytes = 8'd9;
        n = 0;
        while (!bus.tx_valid && n < 50) begin
            tick(1);
            n++;
        end
        check("gap_rise_cycles", n, 32'd9);
        check("gap_second_data", {24'd0, bus.tx_data}, 32'h11);
        check("busy_disp_speed", {24'd0, disp_speed}, 32'd2);
        check("busy_disp_bytes", {24'd0, disp_bytes}, 32'd2);
        wait_idle(20);

        // 4. Back-pressure: data held stable while tx_ready is low.
        cfg_bytes    = 8'd2;
        cfg_speed    = 8'd0;
        cfg_first    = 8'h40;
        bus.tx_ready = 1'b0;
        exp_bytes.push_back(8'h40);
        exp_bytes.push_back(8'h41);
        exp_done.push_back({8'd2, 8'h41});
        pulse_start();
        for (int i = 0; i < 5; i++) begin
            check("stall_valid", {31'd0, bus.tx_valid}, 32'd1);
            check("stall_data", {24'd0, bus.tx_data}, 32'h40);
            check("stall_count", {24'd0, disp_count}, 32'd0);
            tick(1);
        end
        bus.tx_ready = 1'b1;
        wait_idle(20);
        check("stall_final_count", {24'd0, disp_count}, 32'd2);

        // 5. Zero-length burst: straight to DONE, disp_num retained.
        cfg_bytes = 8'd0;
        exp_done.push_back({8'd0, 8'h41});
        pulse_start();
        check("zero_done", {31'd0, done}, 32'd1);
        check("zero_busy", {31'd0, busy}, 32'd1);
        check("zero_valid", {31'd0, bus.tx_valid}, 32'd0);
        tick(1);
        check("zero_done_end", {31'd0, done}, 32'd0);
        check("zero_busy_end", {31'd0, busy}, 32'd0);
        check("zero_count", {24'd0, disp_count}, 32'd0);

        // Abort wins over start in IDLE.
        cfg_bytes = 8'd4;
        abort     = 1'b1;
        pulse_start();
        abort = 1'b0;
        check("abort_over_start", {31'd0, busy}, 32'd0);

        // 6. Abort during GAP of a 4-byte burst.
        cfg_bytes = 8'd4;
        cfg_speed = 8'd1;
        cfg_first = 8'h20;
        exp_bytes.push_back(8'h20);
        pulse_start();
        tick(1);
        tick(2);
        check("gap_valid_low", {31'd0, bus.tx_valid}, 32'd0);
        abort = 1'b1;
        tick(1);
        abort = 1'b0;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_valid", {31'd0, bus.tx_valid}, 32'd0);
        check("abort_done", {31'd0, done}, 32'd0);
        check("abort_count", {24'd0, disp_count}, 32'd1);
        check("abort_num", {24'd0, disp_num}, 32'h20);
        tick(8);
        check("abort_stays_idle", {31'd0, bus.tx_valid}, 32'd0);

        // Reset asserted mid-SEND clears outputs without a clock edge.
        cfg_bytes    = 8'd5;
        cfg_speed    = 8'd0;
        cfg_first    = 8'h33;
        bus.tx_ready = 1'b0;
        pulse_start();
        check("pre_reset_valid", {31'd0, bus.tx_valid}, 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check_all_zero("async_reset");
        tick(2);
        reset = 1'b1;
        tick(2);

        check("scoreboard_bytes_left", exp_bytes.size(), 32'd0);
        check("scoreboard_done_left", exp_done.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time bound so a stuck run still ends with a report.
    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
